// File: rtl/bullet_emitter.sv
// Player bullet pool: spawns single or double volleys from the plane nose,
// moves bullets upward on each move tick, retires them at the top edge or
// on an enemy hit, and exposes a registered random-access read port.
module bullet_emitter #(
   parameter int SLOT_NUM = 8,
   parameter int STEP     = 4,
   parameter int COOLDOWN = 16,
   parameter int OFFSET   = 12,
   parameter int X_MAX    = 639
) (
   input  logic                          clk_run,
   input  logic                          rst,
   input  logic                          en_i,
   input  logic                          move_tick_i,
   input  logic                          fire_i,
   input  logic                          shoot_mode_i,
   input  logic [9:0]                    plane_x_i,
   input  logic [9:0]                    plane_y_i,
   input  logic                          hit_i,
   input  logic [$clog2(SLOT_NUM)-1:0]   hit_idx_i,
   input  logic [$clog2(SLOT_NUM)-1:0]   rd_idx_i,
   output logic                          rd_valid_o,
   output logic [9:0]                    rd_x_o,
   output logic [9:0]                    rd_y_o,
   output logic                          shot_o,
   output logic [$clog2(SLOT_NUM):0]     active_cnt_o
);

   localparam int IDX_W = $clog2(SLOT_NUM);
   localparam int CNT_W = IDX_W + 1;
   localparam int CD_W  = $clog2(COOLDOWN + 1);

   localparam logic [9:0]      STEP_Y    = 10'(STEP);
   localparam logic [10:0]     OFFSET_X  = 11'(OFFSET);
   localparam logic [10:0]     X_MAX_X   = 11'(X_MAX);
   localparam logic [CD_W-1:0] CD_RELOAD = CD_W'(COOLDOWN - 1);

   typedef struct packed {
      logic       valid;
      logic [9:0] x;
      logic [9:0] y;
   } slot_t;

   slot_t            slot_q [SLOT_NUM];
   slot_t            slot_d [SLOT_NUM];
   logic [CD_W-1:0]  cd_q;

   logic             first_found;
   logic             second_found;
   logic [IDX_W-1:0] first_idx;
   logic [IDX_W-1:0] second_idx;

   logic [10:0]      x_ext;
   logic [10:0]      x_sum;
   logic [9:0]       left_x;
   logic [9:0]       right_x;
   logic [9:0]       first_x;

   logic             volley;
   logic [CNT_W-1:0] valid_cnt;

   // Locate the two lowest-index free slots using pre-edge slot state.
   always_comb begin
      // NOTE: every variable written here gets a default first, so no path
      // through the loop can leave it unassigned and infer a latch.
      first_found  = 1'b0;
      second_found = 1'b0;
      first_idx    = '0;
      second_idx   = '0;
      for (int i = 0; i < SLOT_NUM; i++) begin
         if (!slot_q[i].valid) begin
            if (!first_found) begin
               first_found = 1'b1;
               first_idx   = IDX_W'(i);
            end else if (!second_found) begin
               second_found = 1'b1;
               second_idx   = IDX_W'(i);
            end
         end
      end
   end

   // Saturated spawn x positions for the left and right double-mode bullets.
   always_comb begin
      x_ext   = {1'b0, plane_x_i};
      x_sum   = x_ext + OFFSET_X;
      left_x  = (x_ext < OFFSET_X) ? 10'd0 : 10'(x_ext - OFFSET_X);
      right_x = (x_sum > X_MAX_X) ? X_MAX_X[9:0] : x_sum[9:0];
      first_x = shoot_mode_i ? left_x : plane_x_i;
   end

   // A volley needs a qualifying tick, an expired cooldown and a free slot.
   assign volley = en_i & move_tick_i & fire_i & (cd_q == '0) & first_found;

   // Slot next state: move/retire, then hit clear, then spawn into free slots.
   always_comb begin
      for (int i = 0; i < SLOT_NUM; i++) begin
         slot_d[i] = slot_q[i];
         if (en_i && move_tick_i && slot_q[i].valid) begin
            if (slot_q[i].y >= STEP_Y) begin
               slot_d[i].y = slot_q[i].y - STEP_Y;
            end else begin
               slot_d[i].valid = 1'b0;
            end
         end
         if (hit_i && (hit_idx_i == IDX_W'(i))) begin
            slot_d[i].valid = 1'b0;
         end
         // Spawn targets were free before the edge, so a hit there is moot.
         if (volley && (first_idx == IDX_W'(i))) begin
            slot_d[i] = '{valid: 1'b1, x: first_x, y: plane_y_i};
         end
         if (volley && shoot_mode_i && second_found && (second_idx == IDX_W'(i))) begin
            slot_d[i] = '{valid: 1'b1, x: right_x, y: plane_y_i};
         end
      end
   end

   // Number of valid slots in the current state.
   always_comb begin
      valid_cnt = '0;
      for (int i = 0; i < SLOT_NUM; i++) begin
         valid_cnt = valid_cnt + CNT_W'(slot_q[i].valid);
      end
   end

   // Slot storage register.
   always_ff @(posedge clk_run or posedge rst) begin
      // NOTE: the whole slot array is cleared on reset so stale coordinates
      // never reach the read port; non-blocking assignments keep every
      // register updating from the same pre-edge values.
      if (rst) begin
         for (int i = 0; i < SLOT_NUM; i++) begin
            slot_q[i] <= '0;
         end
      end else begin
         slot_q <= slot_d;
      end
   end

   // Cooldown counter: reload on a volley, otherwise count down per tick.
   always_ff @(posedge clk_run or posedge rst) begin
      if (rst) begin
         cd_q <= '0;
      end else if (en_i && move_tick_i) begin
         if (volley) begin
            cd_q <= CD_RELOAD;
         end else if (cd_q != '0) begin
            cd_q <= cd_q - 1'b1;
         end
      end
   end

   // Registered outputs: shot pulse, occupancy count and read port.
   always_ff @(posedge clk_run or posedge rst) begin
      if (rst) begin
         shot_o       <= 1'b0;
         active_cnt_o <= '0;
         rd_valid_o   <= 1'b0;
         rd_x_o       <= '0;
         rd_y_o       <= '0;
      end else begin
         shot_o       <= volley;
         active_cnt_o <= valid_cnt;
         rd_valid_o   <= slot_q[rd_idx_i].valid;
         rd_x_o       <= slot_q[rd_idx_i].x;
         rd_y_o       <= slot_q[rd_idx_i].y;
      end
   end

endmodule

// File: tb/tb_bullet_emitter.sv
// Self-checking bench for bullet_emitter: directed scenarios plus a random
// run, all compared against a slot-list reference model.
module tb_bullet_emitter;

   localparam int SLOT_NUM = 8;
   localparam int IDX_W    = 3;
   localparam int STEP     = 4;
   localparam int COOLDOWN = 16;
   localparam int OFFSET   = 12;
   localparam int X_MAX    = 639;

   logic             clk_run = 1'b0;
   logic             rst;
   logic             en;
   logic             tick;
   logic             fire;
   logic             mode;
   logic [9:0]       px;
   logic [9:0]       py;
   logic             hit;
   logic [IDX_W-1:0] hidx;
   logic [IDX_W-1:0] ridx;
   logic             rd_valid;
   logic [9:0]       rd_x;
   logic [9:0]       rd_y;
   logic             shot;
   logic [IDX_W:0]   active_cnt;

   int total_cnt = 0;
   int pass_cnt  = 0;

   // Reference model state
   bit m_valid [SLOT_NUM];
   int m_x     [SLOT_NUM];
   int m_y     [SLOT_NUM];
   int m_cd;

   bullet_emitter #(
      .SLOT_NUM (SLOT_NUM),
      .STEP     (STEP),
      .COOLDOWN (COOLDOWN),
      .OFFSET   (OFFSET),
      .X_MAX    (X_MAX)
   ) dut (
      .clk_run      (clk_run),
      .rst          (rst),
      .en_i         (en),
      .move_tick_i  (tick),
      .fire_i       (fire),
      .shoot_mode_i (mode),
      .plane_x_i    (px),
      .plane_y_i    (py),
      .hit_i        (hit),
      .hit_idx_i    (hidx),
      .rd_idx_i     (ridx),
      .rd_valid_o   (rd_valid),
      .rd_x_o       (rd_x),
      .rd_y_o       (rd_y),
      .shot_o       (shot),
      .active_cnt_o (active_cnt)
   );

   always #5 clk_run = ~clk_run;

   task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      total_cnt++;
      if (actual !== expected) begin
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
      end else begin
         pass_cnt++;
      end
   endtask

   function automatic void model_clear();
      for (int i = 0; i < SLOT_NUM; i++) begin
         m_valid[i] = 1'b0;
         m_x[i]     = 0;
         m_y[i]     = 0;
      end
      m_cd = 0;
   endfunction

   // Advance the model by one edge, run the edge, then compare all outputs.
   task automatic run_cycle();
      bit pv [SLOT_NUM];
      int pxs [SLOT_NUM];
      int pys [SLOT_NUM];
      int free_q[$];
      int pcnt;
      bit vol;
      int lx, rx;
      pcnt = 0;
      for (int i = 0; i < SLOT_NUM; i++) begin
         pv[i]  = m_valid[i];
         pxs[i] = m_x[i];
         pys[i] = m_y[i];
         if (m_valid[i]) pcnt++;
         else free_q.push_back(i);
      end
      vol = en && tick && fire && (m_cd == 0) && (free_q.size() > 0);
      for (int i = 0; i < SLOT_NUM; i++) begin
         if (en && tick && m_valid[i]) begin
            if (m_y[i] >= STEP) m_y[i] = m_y[i] - STEP;
            else m_valid[i] = 1'b0;
         end
      end
      if (hit) m_valid[int'(hidx)] = 1'b0;
      if (vol) begin
         lx = int'(px) - OFFSET;
         if (lx < 0) lx = 0;
         rx = int'(px) + OFFSET;
         if (rx > X_MAX) rx = X_MAX;
         m_valid[free_q[0]] = 1'b1;
         m_x[free_q[0]]     = mode ? lx : int'(px);
         m_y[free_q[0]]     = int'(py);
         if (mode && free_q.size() >= 2) begin
            m_valid[free_q[1]] = 1'b1;
            m_x[free_q[1]]     = rx;
            m_y[free_q[1]]     = int'(py);
         end
      end
      if (en && tick) begin
         if (vol) m_cd = COOLDOWN - 1;
         else if (m_cd > 0) m_cd = m_cd - 1;
      end
      @(posedge clk_run);
      #1;
      check("shot", shot, vol);
      check("active_cnt", active_cnt, pcnt);
      check("rd_valid", rd_valid, pv[int'(ridx)]);
      if (pv[int'(ridx)]) begin
         check("rd_x", rd_x, pxs[int'(ridx)]);
         check("rd_y", rd_y, pys[int'(ridx)]);
      end
   endtask

   task automatic set_idle();
      en   = 1'b1;
      tick = 1'b0;
      fire = 1'b0;
      hit  = 1'b0;
   endtask

   // One cycle with the given tick/fire levels; other inputs as left.
   task automatic step(input logic t, input logic f);
      tick = t;
      fire = f;
      run_cycle();
      tick = 1'b0;
      fire = 1'b0;
      hit  = 1'b0;
   endtask

   // Idle cycle that presents slot idx on the read port afterwards.
   task automatic read_slot(input int idx);
      set_idle();
      ridx = IDX_W'(idx);
      run_cycle();
   endtask

   // Asynchronous reset between clock edges; outputs must clear at once.
   task automatic do_reset();
      rst = 1'b1;
      #2;
      check("rst_shot", shot, 0);
      check("rst_cnt", active_cnt, 0);
      check("rst_rd_valid", rd_valid, 0);
      check("rst_rd_x", rd_x, 0);
      check("rst_rd_y", rd_y, 0);
      model_clear();
      #2;
      rst = 1'b0;
      set_idle();
   endtask

   initial begin
      int shot_t[3];
      int n_shots;
      rst  = 1'b1;
      en   = 1'b0;
      tick = 1'b0;
      fire = 1'b0;
      mode = 1'b0;
      px   = '0;
      py   = '0;
      hit  = 1'b0;
      hidx = '0;
      ridx = '0;
      model_clear();
      #12;
      check("rst_shot", shot, 0);
      check("rst_cnt", active_cnt, 0);
      check("rst_rd_valid", rd_valid, 0);
      check("rst_rd_x", rd_x, 0);
      check("rst_rd_y", rd_y, 0);
      rst = 1'b0;
      set_idle();

      // Single shot and one move
      mode = 1'b0; px = 10'd320; py = 10'd400; ridx = '0;
      step(1'b1, 1'b1);
      check("single_shot", shot, 1);
      read_slot(0);
      check("single_x", rd_x, 320);
      check("single_y", rd_y, 400);
      check("single_cnt", active_cnt, 1);
      step(1'b1, 1'b0);
      read_slot(0);
      check("single_move_y", rd_y, 396);

      // Double mode with left clamp
      do_reset();
      mode = 1'b1; px = 10'd5; py = 10'd300;
      step(1'b1, 1'b1);
      read_slot(0);
      check("dbl_lo_left_x", rd_x, 0);
      read_slot(1);
      check("dbl_lo_right_x", rd_x, 17);
      check("dbl_lo_right_v", rd_valid, 1);

      // Double mode with right clamp
      do_reset();
      px = 10'd635;
      step(1'b1, 1'b1);
      read_slot(0);
      check("dbl_hi_left_x", rd_x, 623);
      read_slot(1);
      check("dbl_hi_right_x", rd_x, 639);

      // Cooldown with fire held high for 40 ticks
      do_reset();
      mode = 1'b0; px = 10'd100; py = 10'd1000;
      n_shots = 0;
      for (int i = 0; i < 3; i++) shot_t[i] = -1;
      for (int t = 0; t < 40; t++) begin
         step(1'b1, 1'b1);
         if (shot === 1'b1) begin
            if (n_shots < 3) shot_t[n_shots] = t;
            n_shots++;
         end
      end
      check("cd_volleys", n_shots, 3);
      check("cd_tick0", shot_t[0], 0);
      check("cd_tick16", shot_t[1], 16);
      check("cd_tick32", shot_t[2], 32);

      // Exit at the top edge
      do_reset();
      mode = 1'b0; px = 10'd50; py = 10'd3;
      step(1'b1, 1'b1);
      step(1'b1, 1'b0);
      check("exit_cnt_before", active_cnt, 1);
      read_slot(0);
      check("exit_gone", rd_valid, 0);
      check("exit_cnt_after", active_cnt, 0);
      do_reset();
      py = 10'd4;
      step(1'b1, 1'b1);
      step(1'b1, 1'b0);
      read_slot(0);
      check("edge_valid", rd_valid, 1);
      check("edge_y0", rd_y, 0);

      // Fill all slots, then full and partial volleys
      do_reset();
      mode = 1'b1; px = 10'd320; py = 10'd900;
      for (int t = 0; t < 49; t++) step(1'b1, 1'b1);
      for (int t = 0; t < 20; t++) step(1'b1, 1'b0);
      check("full_cnt", active_cnt, 8);
      step(1'b1, 1'b1);
      check("full_no_shot", shot, 0);
      step(1'b1, 1'b1);
      check("full_no_shot2", shot, 0);
      hit = 1'b1; hidx = 3'd5;
      step(1'b0, 1'b0);
      px = 10'd5;
      step(1'b1, 1'b1);
      check("partial_shot", shot, 1);
      read_slot(5);
      check("partial_valid", rd_valid, 1);
      check("partial_x", rd_x, 0);
      check("partial_y", rd_y, 900);
      check("partial_cnt", active_cnt, 8);

      // Hit and move on the same slot, then a hit on an empty slot
      hit = 1'b1; hidx = 3'd2;
      step(1'b1, 1'b0);
      read_slot(2);
      check("collide_gone", rd_valid, 0);
      check("collide_cnt", active_cnt, 7);
      hit = 1'b1; hidx = 3'd2;
      step(1'b0, 1'b0);
      read_slot(2);
      check("empty_hit_v", rd_valid, 0);
      check("empty_hit_cnt", active_cnt, 7);

      // Reset in flight
      do_reset();
      read_slot(0);
      check("post_rst_cnt", active_cnt, 0);

      // Randomized run against the model
      for (int c = 0; c < 1500; c++) begin
         en   = ($urandom_range(0, 9) != 0);
         tick = ($urandom_range(0, 1) == 1);
         fire = ($urandom_range(0, 2) != 0);
         mode = $urandom_range(0, 1);
         case ($urandom_range(0, 4))
            0:       px = 10'($urandom_range(0, 15));
            1:       px = 10'($urandom_range(624, 639));
            default: px = 10'($urandom_range(0, 639));
         endcase
         py   = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 12))
                                            : 10'($urandom_range(0, 1023));
         hit  = ($urandom_range(0, 6) == 0);
         hidx = IDX_W'($urandom_range(0, SLOT_NUM - 1));
         ridx = IDX_W'($urandom_range(0, SLOT_NUM - 1));
         if ($urandom_range(0, 299) == 0) begin
            do_reset();
         end else begin
            run_cycle();
         end
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/bullet_emitter.md
BULLET_EMITTER -- requirements
Module: bullet_emitter

Interface
REQ-001 Parameter SLOT_NUM, default 8, number of player-bullet slots (power of two, 2..16).
REQ-002 Parameter STEP, default 4, pixels a bullet rises per move tick.
REQ-003 Parameter COOLDOWN, default 16, move ticks between successive volleys.
REQ-004 Parameter OFFSET, default 12, horizontal half-spacing of double-mode bullets.
REQ-005 Parameter X_MAX, default 639, largest legal x coordinate.
REQ-006 clk_run  input  1  run clock; all state on rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 en_i  input  1  game running; low freezes all state.
REQ-009 move_tick_i  input  1  one-cycle pulse; advances bullets, cooldown and firing.
REQ-010 fire_i  input  1  fire request, level, sampled only on move_tick_i.
REQ-011 shoot_mode_i  input  1  0 = single, 1 = double (matches BULLET_MODE_SINGLE/DOUBLE).
REQ-012 plane_x_i  input  10  player nose x.
REQ-013 plane_y_i  input  10  player nose y.
REQ-014 hit_i  input  1  one-cycle pulse; slot hit_idx_i struck an enemy.
REQ-015 hit_idx_i  input  log2(SLOT_NUM)  slot index for hit_i.
REQ-016 rd_idx_i  input  log2(SLOT_NUM)  slot read index.
REQ-017 rd_valid_o / rd_x_o / rd_y_o  output  1/10/10  registered contents of slot rd_idx_i.
REQ-018 shot_o  output  1  one-cycle pulse when at least one bullet spawned.
REQ-019 active_cnt_o  output  log2(SLOT_NUM)+1  registered count of valid slots.

Function
REQ-020 Each slot holds valid, x[9:0], y[9:0]; all slots invalid after reset.
REQ-021 Read port latency one cycle: outputs in cycle n+1 reflect rd_idx_i and slot state at edge n.
REQ-022 en_i low: no movement, spawn, cooldown change or shot_o; hit_i still clears slots.
REQ-023 On move_tick_i with en_i high, each valid slot with y >= STEP gets y <= y - STEP; each valid slot with y < STEP goes invalid (no wrap-around).
REQ-024 Cooldown counter cd: on move_tick_i, if cd != 0 then cd <= cd - 1.
REQ-025 Volley fires on move_tick_i when en_i=1, fire_i=1 and cd==0; cd <= COOLDOWN-1.
REQ-026 Volley with cd==0 but no free slot: no spawn, shot_o stays 0, cd unchanged.
REQ-027 Single mode spawns one bullet at (plane_x_i, plane_y_i) in the lowest-index free slot.
REQ-028 Double mode spawns left bullet at (sat(plane_x_i - OFFSET), plane_y_i) in the lowest free slot and right bullet at (sat(plane_x_i + OFFSET), plane_y_i) in the next free slot.
REQ-029 sat clamps to 0 on underflow and to X_MAX on overflow; arithmetic uses 11 bits.
REQ-030 Double mode with exactly one free slot: left bullet only; shot_o=1; cd reloaded.
REQ-031 Free-slot search uses state before the current edge; slots freed by this edge's move or hit are not reused until the next tick.
REQ-032 Newly spawned bullets are not moved on their spawn tick.
REQ-033 hit_i clears slot hit_idx_i at the next edge; hit on an invalid slot is ignored.
REQ-034 hit_i and move_tick_i on the same slot in the same cycle: slot ends invalid.
REQ-035 shoot_mode_i sampled only at the volley tick; a mode change does not affect bullets in flight.
REQ-036 shot_o is registered, high exactly one cycle after a spawning edge.
REQ-037 active_cnt_o equals the number of valid slots, one cycle after slot state.

Reset
REQ-038 Asserting rst clears all slots, cd=0, shot_o=0, active_cnt_o=0, rd_valid_o=0, rd_x_o=0, rd_y_o=0, at any time, including mid-volley.
REQ-039 After rst deasserts, the first qualifying tick may fire (cd=0).

Verification
REQ-040 Single shot: mode=0, plane=(320,400), fire=1, tick -> slot0=(320,400), shot_o pulse, active_cnt_o=1; next tick slot0 y=396.
REQ-041 Double with clamp: mode=1, plane_x=5 -> slots 0/1 = (0,y) and (17,y); plane_x=635 -> second bullet x=639.
REQ-042 Cooldown: fire held high, 40 ticks -> volleys on ticks 0, 16 and 32 only.
REQ-043 Exit: bullet at y=3, tick -> slot invalid, active_cnt_o decrements; bullet at y=4 -> y=0, still valid.
REQ-044 Full and partial: 8 valid slots, fire -> no spawn, cd stays 0; 7 valid, double -> one bullet, in the free slot.
REQ-045 Hit and move collide: hit_i idx 2 with move_tick_i -> slot 2 invalid; hit on an empty slot -> no change; rst mid-flight -> all outputs 0.
